// File: rtl/cntsel_pkg.sv
// Shared types and helpers for the byte-serial bit-select unit.
// State encoding and the operand byte-count helper live here.
package cntsel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic int bytes_of(input int wid);
    return wid / 8;
  endfunction

endpackage

// File: rtl/cntpop8.sv
// 8-bit population count, shared with the ALU popcount path.
module cntpop8 (
  input  logic [7:0] b_i,
  output logic [3:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int j = 0; j < 8; j++) begin
      cnt_o = cnt_o + {3'b000, b_i[j]};
    end
  end

endmodule

// File: rtl/cntsel8.sv
// 8-bit select: position of the k-th set bit in a byte.
// Result is don't-care when k >= popcount(byte).
module cntsel8 (
  input  logic [7:0] b_i,
  input  logic [2:0] k_i,
  output logic [2:0] pos_o
);

  // Packed ascending set-bit positions of a nibble, 2 bits each.
  function automatic logic [1:0] sel4(
    input logic [3:0] nib,
    input logic [1:0] k
  );
    logic [7:0] t;
    case (nib)
      4'h1:    t = 8'h00;
      4'h2:    t = 8'h01;
      4'h3:    t = 8'h04;
      4'h4:    t = 8'h02;
      4'h5:    t = 8'h08;
      4'h6:    t = 8'h09;
      4'h7:    t = 8'h24;
      4'h8:    t = 8'h03;
      4'h9:    t = 8'h0C;
      4'hA:    t = 8'h0D;
      4'hB:    t = 8'h34;
      4'hC:    t = 8'h0E;
      4'hD:    t = 8'h38;
      4'hE:    t = 8'h39;
      4'hF:    t = 8'hE4;
      default: t = 8'h00;
    endcase
    return t[{k, 1'b0} +: 2];
  endfunction

  logic [2:0] cl;

  assign cl = {2'b00, b_i[0]} + {2'b00, b_i[1]}
            + {2'b00, b_i[2]} + {2'b00, b_i[3]};

  always_comb begin
    if (k_i < cl) begin
      pos_o = {1'b0, sel4(b_i[3:0], k_i[1:0])};
    end else begin
      pos_o = {1'b1, sel4(b_i[7:4], 2'(k_i - cl))};
    end
  end

endmodule

// File: rtl/cntsel64.sv
// Byte-serial select unit: finds the n-th set bit of an operand,
// skipping whole bytes by popcount, one byte per clock.
module cntsel64
  import cntsel_pkg::*;
#(
  parameter int WID = 64,
  parameter int PW  = $clog2(WID)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ld,
  input  logic [WID-1:0] i,
  input  logic [PW-1:0]  n,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [PW-1:0]  o
);

  localparam int BYTES = bytes_of(WID);
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_e         state_q, state_d;
  logic [WID-1:0] opr_q, opr_d;
  logic [PW-1:0]  rem_q, rem_d;
  logic [PW-1:0]  o_q, o_d;
  logic [BW-1:0]  bi_q, bi_d;
  logic           done_q, done_d;
  logic           found_q, found_d;

  logic [7:0] byte_w;
  logic [3:0] cnt_w;
  logic [2:0] pos_w;
  logic       hit_w;
  logic       last_w;

  assign byte_w = opr_q[{bi_q, 3'b000} +: 8];

  cntpop8 u_pop (
    .b_i   (byte_w),
    .cnt_o (cnt_w)
  );

  cntsel8 u_sel (
    .b_i   (byte_w),
    .k_i   (rem_q[2:0]),
    .pos_o (pos_w)
  );

  assign hit_w  = {4'b0000, rem_q} < {PW'(0), cnt_w};
  assign last_w = (bi_q == BW'(BYTES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      opr_q   <= '0;
      rem_q   <= '0;
      o_q     <= '0;
      bi_q    <= '0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      rem_q   <= rem_d;
      o_q     <= o_d;
      bi_q    <= bi_d;
      done_q  <= done_d;
      found_q <= found_d;
    end
  end

  // A new ld always wins, aborting any scan in flight.
  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    rem_d   = rem_q;
    o_d     = o_q;
    bi_d    = bi_q;
    found_d = found_q;
    done_d  = 1'b0;
    priority case (1'b1)
      ld: begin
        opr_d   = i;
        rem_d   = n;
        bi_d    = '0;
        o_d     = '0;
        found_d = 1'b0;
        state_d = SCAN;
      end
      (state_q == SCAN) && hit_w: begin
        o_d     = PW'({bi_q, pos_w});
        found_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      (state_q == SCAN) && last_w: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      (state_q == SCAN): begin
        rem_d = rem_q - PW'(cnt_w);
        bi_d  = bi_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy  = (state_q == SCAN);
    done  = done_q;
    found = found_q;
    o     = o_q;
  end

endmodule

// File: tb/tb_cntsel64.sv
// Testbench for cntsel64: vector table, corner sequences and
// randomized operands against a rank-walking select model.
module tb_cntsel64;

  localparam int WID = 64;
  localparam int PW  = 6;

  typedef struct {
    logic [63:0] a;
    logic [5:0]  b;
    logic        f;
    logic [5:0]  p;
    int          lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld  = 1'b0;
  logic [63:0]   iv  = '0;
  logic [PW-1:0] nv  = '0;
  logic          busy;
  logic          done;
  logic          found;
  logic [PW-1:0] o;

  int errs   = 0;
  int checks = 0;

  cntsel64 #(.WID(WID)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ld    (ld),
    .i     (iv),
    .n     (nv),
    .busy  (busy),
    .done  (done),
    .found (found),
    .o     (o)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) chk("done_with_busy", 64'(busy), 64'd0);
  end

  // Reference: walk the set bits in rank order.
  task automatic model(
    input  logic [63:0] a,
    input  int          b,
    output logic        f,
    output logic [5:0]  p,
    output int          lat
  );
    int cnt;
    cnt = 0;
    f   = 1'b0;
    p   = '0;
    lat = WID / 8;
    for (int j = 0; j < WID; j++) begin
      if (a[j]) begin
        if (cnt == b) begin
          f   = 1'b1;
          p   = 6'(j);
          lat = j / 8 + 1;
          break;
        end
        cnt++;
      end
    end
  endtask

  task automatic start(input logic [63:0] a, input logic [5:0] b);
    @(negedge clk);
    ld = 1'b1;
    iv = a;
    nv = b;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(
    input string       nm,
    input logic [63:0] a,
    input logic [5:0]  b,
    input logic        ef,
    input logic [5:0]  ep,
    input int          elat,
    input bit          pulse
  );
    int lat;
    start(a, b);
    wait_done(lat);
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_found"}, 64'(found), 64'(ef));
    chk({nm, "_o"}, 64'(o), 64'(ep));
    if (pulse && lat != 0) begin
      @(negedge clk);
      chk({nm, "_pulse"}, 64'(done), 64'd0);
      chk({nm, "_hold"}, 64'(o), 64'(ep));
    end
  endtask

  initial begin
    vec_t        vt[10];
    int          lat;
    int          nd;
    int          pc;
    int          b;
    logic [63:0] a;
    logic        f;
    logic [5:0]  p;

    vt[0] = '{64'h1, 6'd0, 1'b1, 6'd0, 1};
    vt[1] = '{64'h8000_0000_0000_0000, 6'd0, 1'b1, 6'd63, 8};
    vt[2] = '{64'h0000_00F0_0000_0F00, 6'd5, 1'b1, 6'd37, 5};
    vt[3] = '{64'h0, 6'd0, 1'b0, 6'd0, 8};
    vt[4] = '{64'hFF, 6'd8, 1'b0, 6'd0, 8};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b1, 6'd63, 8};
    vt[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd37, 1'b1, 6'd37, 5};
    vt[7] = '{64'h80, 6'd0, 1'b1, 6'd7, 1};
    vt[8] = '{64'hAA, 6'd3, 1'b1, 6'd7, 1};
    vt[9] = '{64'h0100_0000_0000_0000, 6'd0, 1'b1, 6'd56, 8};

    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_o", 64'(o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_op($sformatf("vec%0d", v), vt[v].a, vt[v].b,
             vt[v].f, vt[v].p, vt[v].lat, 1'b1);
    end

    // Restart: second ld lands on the third clock of a scan.
    start(64'h8000_0000_0000_0000, 6'd0);
    @(negedge clk);
    chk("restart_busy", 64'(busy), 64'd1);
    @(negedge clk);
    ld = 1'b1;
    iv = 64'hFFFF_FFFF_FFFF_FFFF;
    nv = 6'd37;
    @(negedge clk);
    ld = 1'b0;
    wait_done(lat);
    chk("restart_lat", 64'(lat), 64'd5);
    chk("restart_found", 64'(found), 64'd1);
    chk("restart_o", 64'(o), 64'd37);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("restart_single_done", 64'(nd), 64'd0);

    // ld during the done cycle starts the next scan.
    start(64'h1, 6'd0);
    wait_done(lat);
    chk("ldone_first_lat", 64'(lat), 64'd1);
    ld = 1'b1;
    iv = 64'h100;
    nv = 6'd0;
    @(negedge clk);
    ld = 1'b0;
    chk("ldone_busy", 64'(busy), 64'd1);
    chk("ldone_done_low", 64'(done), 64'd0);
    wait_done(lat);
    chk("ldone_lat", 64'(lat), 64'd2);
    chk("ldone_o", 64'(o), 64'd8);
    chk("ldone_found", 64'(found), 64'd1);

    // Async reset mid-scan.
    start(64'h0, 6'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_pre", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_found", 64'(found), 64'd0);
    chk("midrst_o", 64'(o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);

    // Async reset while done and a held result are showing.
    start(64'h80, 6'd0);
    wait_done(lat);
    chk("dnrst_o_pre", 64'(o), 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("dnrst_done", 64'(done), 64'd0);
    chk("dnrst_found", 64'(found), 64'd0);
    chk("dnrst_o", 64'(o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 5000; r++) begin
      a = {$urandom, $urandom};
      case (r % 4)
        1: a = a & {$urandom, $urandom} & {$urandom, $urandom};
        2: a = a | {$urandom, $urandom};
        3: a = a & (64'hFF << (8 * $urandom_range(0, 7)));
        default: ;
      endcase
      pc = $countones(a);
      b  = $urandom_range(0, (pc + 1 > 63) ? 63 : pc + 1);
      model(a, b, f, p, lat);
      run_op("rand", a, 6'(b), f, p, lat, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
